dispatch_arbiter: RTL and testbench

Clocked, parametrised successor of the two-core instruction arbiter. It accepts one instruction per cycle over a valid/ready handshake and dispatches it into one of NUM_CORES per-core FIFOs. Dispatch is round-robin unless the instruction is force-steered or has a register hazard against entries queued for another core. The block sits between the fetch/decode stage and the per-core pipelines, and each core pops its own FIFO.

---
 rtl/dispatch_arbiter.sv | 149 ++++++++++++++
 tb/tb_dispatch_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/dispatch_arbiter.sv
// Dispatches one instruction per cycle into NUM_CORES per-core FIFOs, round-robin
// unless force-steered or serialised behind a register hazard on a single core.
module dispatch_arbiter #(
  parameter int NUM_CORES = 2,
  parameter int DEPTH     = 8,
  parameter int DATA_W    = 32
) (
  input  logic                                   clk,
  input  logic                                   resetn,
  input  logic [DATA_W-1:0]                      in_instr,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  output logic [NUM_CORES*DATA_W-1:0]            out_instr,
  output logic [NUM_CORES-1:0]                   out_valid,
  input  logic [NUM_CORES-1:0]                   out_ready,
  output logic [NUM_CORES*($clog2(DEPTH)+1)-1:0] fifo_count,
  output logic [$clog2(NUM_CORES)-1:0]           disp_core,
  output logic [15:0]                            hazard_stall_cnt
);
  localparam int CID_W = $clog2(NUM_CORES);
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;

  logic [DATA_W-1:0] mem    [NUM_CORES][DEPTH];
  logic [PW-1:0]     rd_ptr [NUM_CORES];
  logic [PW-1:0]     wr_ptr [NUM_CORES];
  logic [CW-1:0]     count  [NUM_CORES];
  logic [CID_W-1:0]  rr_ptr;

  logic [NUM_CORES-1:0] hz;
  logic [NUM_CORES-1:0] push_v;
  logic [NUM_CORES-1:0] pop_v;
  logic [CID_W:0]       hz_cnt;
  logic [CID_W-1:0]     hz_idx;
  logic [CID_W-1:0]     target;
  logic                 stall;
  logic                 accept;
  logic [11:0]          in_keys;
  logic                 unused_in;

  // Returns {src_key, dst_key}, each {bank bit, 5-bit register}.
  function automatic logic [11:0] reg_keys(input logic [23:0] v);
    logic [5:0] s;
    logic [5:0] d;
    s = {v[23], v[10] ? v[9:5]   : v[4:0]};
    d = {v[22], v[21] ? v[20:16] : v[15:11]};
    return {s, d};
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign unused_in = ^in_instr;
  assign in_keys   = reg_keys(in_instr[23:0]);

  always_comb begin
    logic [PW-1:0] off;
    logic [11:0]   ek;
    off = '0;
    ek  = '0;
    hz  = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      for (int i = 0; i < DEPTH; i++) begin
        off = PW'(i) - rd_ptr[c];
        ek  = reg_keys(mem[c][i][23:0]);
        // An entry popping this cycle is still occupied and still counts.
        if (({1'b0, off} < count[c]) &&
            ((ek[5:0] == in_keys[11:6]) || (ek[11:6] == in_keys[5:0]) ||
             (ek[5:0] == in_keys[5:0])))
          hz[c] = 1'b1;
      end
    end
    if (in_instr[23] & in_instr[22])
      hz = '0;
  end

  always_comb begin
    hz_cnt = '0;
    hz_idx = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      hz_cnt = hz_cnt + (CID_W+1)'(hz[c]);
      if (hz[c])
        hz_idx = CID_W'(c);
    end
    stall  = 1'b0;
    target = rr_ptr;
    if (in_instr[27])
      target = in_instr[26 -: CID_W];
    else if (hz_cnt == '0)
      target = rr_ptr;
    else if (hz_cnt == (CID_W+1)'(1))
      target = hz_idx;
    else
      stall = 1'b1;
    in_ready = (count[target] != CW'(DEPTH)) && !stall;
  end

  assign accept    = in_valid && in_ready;
  assign disp_core = target;

  always_comb begin
    out_instr  = '0;
    fifo_count = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      out_valid[c] = (count[c] != '0);
      push_v[c]    = accept && (target == CID_W'(c));
      pop_v[c]     = out_valid[c] && out_ready[c];
      fifo_count[c*CW +: CW] = count[c];
      // Empty slices read as zero so stale storage never leaks out.
      if (out_valid[c])
        out_instr[c*DATA_W +: DATA_W] = mem[c][rd_ptr[c]];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int c = 0; c < NUM_CORES; c++) begin
        rd_ptr[c] <= '0;
        wr_ptr[c] <= '0;
        count[c]  <= '0;
      end
      rr_ptr           <= '0;
      hazard_stall_cnt <= '0;
    end else begin
      for (int c = 0; c < NUM_CORES; c++) begin
        if (push_v[c])
          wr_ptr[c] <= wr_ptr[c] + 1'b1;
        if (pop_v[c])
          rd_ptr[c] <= rd_ptr[c] + 1'b1;
        if (push_v[c] && !pop_v[c])
          count[c] <= count[c] + 1'b1;
        else if (pop_v[c] && !push_v[c])
          count[c] <= count[c] - 1'b1;
      end
      if (accept)
        rr_ptr <= target + 1'b1;
      if (in_valid && stall)
        hazard_stall_cnt <= sat_inc16(hazard_stall_cnt);
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CORES; c++)
      if (push_v[c])
        mem[c][wr_ptr[c]] <= in_instr;
  end

endmodule

// File: tb/tb_dispatch_arbiter.sv
// Scoreboard bench for dispatch_arbiter (2 cores, depth 8, 32-bit instructions).
module tb_dispatch_arbiter;
  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] in_instr;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_instr;
  logic [1:0]  out_valid;
  logic [1:0]  out_ready;
  logic [7:0]  fifo_count;
  logic [0:0]  disp_core;
  logic [15:0] hazard_stall_cnt;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] sb0[$];
  logic [31:0] sb1[$];

  dispatch_arbiter #(.NUM_CORES(2), .DEPTH(8), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn), .in_instr(in_instr), .in_valid(in_valid),
    .in_ready(in_ready), .out_instr(out_instr), .out_valid(out_valid),
    .out_ready(out_ready), .fifo_count(fifo_count), .disp_core(disp_core),
    .hazard_stall_cnt(hazard_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction for a single cycle; expected core recorded on accept.
  task automatic send(input logic [31:0] instr, input logic exp_rdy, input logic exp_core);
    in_instr = instr;
    in_valid = 1'b1;
    #1;
    chk("in_ready", in_ready, exp_rdy);
    if (exp_rdy) begin
      chk("disp_core", disp_core, exp_core);
      if (exp_core) sb1.push_back(instr);
      else          sb0.push_back(instr);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic counts(input logic [3:0] c0, input logic [3:0] c1);
    #1;
    chk("count0", fifo_count[3:0], c0);
    chk("count1", fifo_count[7:4], c1);
  endtask

  // Pop monitor: every handshake retires the oldest expected entry for that core.
  always @(negedge clk) begin
    if (resetn) begin
      for (int c = 0; c < 2; c++) begin
        if (out_valid[c] && out_ready[c]) begin
          if (c == 0) begin
            if (sb0.size() == 0) chk("sb0_empty", 1, 0);
            else                 chk("pop_data0", out_instr[31:0], sb0.pop_front());
          end else begin
            if (sb1.size() == 0) chk("sb1_empty", 1, 0);
            else                 chk("pop_data1", out_instr[63:32], sb1.pop_front());
          end
        end
      end
    end
  end

  initial begin
    resetn = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = '0;
    tick(); tick();
    resetn = 1'b1;
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_counts", fifo_count, 0);
    chk("rst_stall_cnt", hazard_stall_cnt, 0);

    // Round-robin without hazards
    send(32'h0000_2801, 1'b1, 1'b0);
    send(32'h0000_4002, 1'b1, 1'b1);
    counts(4'd1, 4'd1);
    chk("ov_after_push", out_valid, 2'b11);
    out_ready = 2'b11; tick(); out_ready = 2'b00;
    counts(4'd0, 4'd0);

    // RAW steering: second instruction reads r5 written by core0's entry
    send(32'h0000_2801, 1'b1, 1'b0);
    send(32'h0000_3805, 1'b1, 1'b0);
    counts(4'd2, 4'd0);
    out_ready = 2'b01; tick(); tick(); out_ready = 2'b00;
    counts(4'd0, 4'd0);

    // Hazards on both cores stall until core1 drains
    send(32'h0800_2801, 1'b1, 1'b0);
    send(32'h0C00_3000, 1'b1, 1'b1);
    in_instr = 32'h0000_3005; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1; chk("stall_rdy", in_ready, 0);
      tick();
    end
    chk("stall_cnt3", hazard_stall_cnt, 16'd3);
    out_ready = 2'b10;
    #1; chk("stall_while_pop", in_ready, 0);
    tick();
    out_ready = 2'b00;
    #1; chk("unstall_rdy", in_ready, 1);
    chk("unstall_core", disp_core, 0);
    sb0.push_back(32'h0000_3005);
    tick();
    in_valid = 1'b0;
    chk("stall_cnt4", hazard_stall_cnt, 16'd4);
    counts(4'd2, 4'd0);
    out_ready = 2'b01; tick(); tick(); out_ready = 2'b00;

    // Fill core1 by force, then full, simultaneous push/pop, forced override
    for (int i = 0; i < 8; i++) send(32'h0C00_0000 + 32'(i), 1'b1, 1'b1);
    counts(4'd0, 4'd8);
    in_instr = 32'h0C00_0100; in_valid = 1'b1;
    #1; chk("full_rdy", in_ready, 0);
    out_ready = 2'b10;
    tick();
    #1; chk("not_full_rdy", in_ready, 1);
    sb1.push_back(32'h0C00_0100);
    tick();
    in_valid = 1'b0; out_ready = 2'b00;
    counts(4'd0, 4'd7);
    send(32'h0C00_0101, 1'b1, 1'b1);
    counts(4'd0, 4'd8);
    send(32'h0800_0000, 1'b1, 1'b0);
    counts(4'd1, 4'd8);
    out_ready = 2'b10; tick(); tick(); out_ready = 2'b00;
    counts(4'd1, 4'd6);

    // Mid-operation reset discards queued entries
    resetn = 1'b0; tick(); resetn = 1'b1;
    sb0.delete(); sb1.delete();
    #1;
    chk("rst2_out_valid", out_valid, 0);
    chk("rst2_counts", fifo_count, 0);
    chk("rst2_stall_cnt", hazard_stall_cnt, 0);
    chk("rst2_in_ready", in_ready, 1);
    send(32'h0000_4002, 1'b1, 1'b0);
    counts(4'd1, 4'd0);
    out_ready = 2'b01; tick(); out_ready = 2'b00;
    counts(4'd0, 4'd0);
    chk("sb_drained", 64'(sb0.size() + sb1.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
